// File: rtl/bit_serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package bit_serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational full-subtractor cell: d = x - y - bin, bout = borrow out.
// Two half-subtractor stages whose borrows are OR-ed together.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half-subtractor: x - y
  assign hs1_d = x ^ y;
  assign hs1_b = ~x & y;

  // Second half-subtractor: (x - y) - bin
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Operands arrive on a valid/ready handshake; the result is held behind a
// valid/ready handshake until the consumer takes it.
// Optional feature: define BIT_SERIAL_SUB_OVF_EN to add the signed overflow
// output ovf (and the operand sign capture that feeds it).
module bit_serial_subtractor
  import bit_serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef BIT_SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_valid_q;
  logic             d_bit;
  logic             bout_bit;

`ifdef BIT_SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  // The single subtractor cell works on the current LSB of each shifter.
  full_subtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Next-state datapath values used while in RUN.
  always_comb begin
    diff_d = {d_bit, diff_q[WIDTH-1:1]};
    cnt_d  = cnt_q + 1'b1;
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef BIT_SERIAL_SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          diff_q <= diff_d;
          br_q   <= bout_bit;
          cnt_q  <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef BIT_SERIAL_SUB_OVF_EN
            // d_bit is the result MSB being shifted in on this final edge.
            ovf_q       <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is decoded from state so it reads 1 throughout reset.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = br_q;
`ifdef BIT_SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH = 8).
// Build with BIT_SERIAL_SUB_OVF_EN defined to also check the ovf output.
module tb_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] diff;
  logic       borrow;
`ifdef BIT_SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef BIT_SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_sub(input logic [7:0] av, input logic [7:0] bv,
                                  output logic [7:0] d, output logic bo, output logic ov);
    int ia, ib, sa, sb, r;
    ia = int'(av);
    ib = int'(bv);
    d  = 8'((ia - ib + 256) % 256);
    bo = (ia < ib);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    r  = sa - sb;
    ov = (r > 127) || (r < -128);
  endfunction

  // Present operands from a falling edge and return just after the accept edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Count edges from the accept edge until out_valid is seen; ends on a falling edge.
  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (diff !== 8'h00 || borrow !== 1'b0) begin
      n_fail++; $display("FAIL reset_result: diff=%h borrow=%0b want 00/0", diff, borrow);
    end
`ifdef BIT_SERIAL_SUB_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    $display("reset: in_ready=%0b out_valid=%0b diff=%h", in_ready, out_valid, diff);
  endtask

  task automatic test_basic();
    logic [7:0] ta[4];
    logic [7:0] tb_[4];
    logic [7:0] ed;
    logic eb, eo;
    int lat;
    ta[0] = 8'd5;  tb_[0] = 8'd3;
    ta[1] = 8'd3;  tb_[1] = 8'd5;
    ta[2] = 8'h00; tb_[2] = 8'hFF;
    ta[3] = 8'h80; tb_[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      ref_sub(ta[i], tb_[i], ed, eb, eo);
      start_op(ta[i], tb_[i]);
      wait_done(lat);
      $display("op a=%h b=%h -> diff=%h borrow=%0b latency=%0d", ta[i], tb_[i], diff, borrow, lat);
      n_checks++;
      if (lat != 8) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d want 8", i, lat); end
      n_checks++;
      if (diff !== ed) begin n_fail++; $display("FAIL basic_diff[%0d]: got %h want %h", i, diff, ed); end
      n_checks++;
      if (borrow !== eb) begin n_fail++; $display("FAIL basic_borrow[%0d]: got %0b want %0b", i, borrow, eb); end
`ifdef BIT_SERIAL_SUB_OVF_EN
      n_checks++;
      if (ovf !== eo) begin n_fail++; $display("FAIL basic_ovf[%0d]: got %0b want %0b", i, ovf, eo); end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL basic_handshake[%0d]: out_valid=%0b in_ready=%0b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed, ed2;
    logic eb, eo, eb2, eo2;
    int lat;
    ref_sub(8'h80, 8'h01, ed, eb, eo);
    ref_sub(8'h33, 8'h44, ed2, eb2, eo2);
    start_op(8'h80, 8'h01);
    wait_done(lat);
    in_valid = 1'b1; a = 8'h33; b = 8'h44;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_ctrl[%0d]: out_valid=%0b in_ready=%0b want 1/0", i, out_valid, in_ready);
      end
      n_checks++;
      if (diff !== ed || borrow !== eb) begin
        n_fail++; $display("FAIL bp_hold_result[%0d]: diff=%h borrow=%0b want %h/%0b", i, diff, borrow, ed, eb);
      end
`ifdef BIT_SERIAL_SUB_OVF_EN
      n_checks++;
      if (ovf !== eo) begin n_fail++; $display("FAIL bp_hold_ovf[%0d]: got %0b want %0b", i, ovf, eo); end
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: in_ready=%0b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    n_checks++;
    if (out_valid !== 1'b1 || diff !== ed2 || borrow !== eb2) begin
      n_fail++; $display("FAIL bp_next_result: valid=%0b diff=%h borrow=%0b want 1/%h/%0b", out_valid, diff, borrow, ed2, eb2);
    end
    $display("backpressure: held %h, next op a=33 b=44 -> diff=%h borrow=%0b", ed, diff, borrow);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    start_op(8'hF0, 8'h0F);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: out_valid=%0b diff=%h borrow=%0b want 0/00/0", out_valid, diff, borrow);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'hFF, 8'hFF);
    wait_done(lat);
    n_checks++;
    if (diff !== 8'h00 || borrow !== 1'b0 || lat != 8) begin
      n_fail++; $display("FAIL abort_next_op: diff=%h borrow=%0b lat=%0d want 00/0/8", diff, borrow, lat);
    end
    $display("abort: after reset op a=FF b=FF -> diff=%h borrow=%0b", diff, borrow);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] av, bv, ea, eb_op, ed;
    logic eb, eo;
    int last_acc = -1;
    int sent = 0, got = 0, guard = 0;
    out_ready = 1'b1;
    while ((sent < 256 || got < 256) && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (out_valid && qa.size() > 0) begin
        ea = qa.pop_front();
        eb_op = qb.pop_front();
        ref_sub(ea, eb_op, ed, eb, eo);
        n_checks++;
        if (diff !== ed || borrow !== eb) begin
          n_fail++; $display("FAIL b2b_result[%0d]: a=%h b=%h diff=%h borrow=%0b want %h/%0b", got, ea, eb_op, diff, borrow, ed, eb);
        end
`ifdef BIT_SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== eo) begin n_fail++; $display("FAIL b2b_ovf[%0d]: got %0b want %0b", got, ovf, eo); end
`endif
        $display("b2b[%0d] a=%h b=%h -> diff=%h borrow=%0b", got, ea, eb_op, diff, borrow);
        got++;
      end
      if (in_ready && sent < 256) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        in_valid = 1'b1; a = av; b = bv;
        qa.push_back(av);
        qb.push_back(bv);
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 10) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", sent, cyc - last_acc);
          end
        end
        last_acc = cyc;
        sent++;
      end else begin
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != 256) begin n_fail++; $display("FAIL b2b_count: got %0d results want 256", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Bit-serial unsigned/two's-complement subtractor that computes `diff = a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's adder cells. It sits behind a valid/ready operand interface and presents a held result behind a valid/ready result interface, trading latency for area in low-rate arithmetic paths.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH >= 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands `a` and `b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: minuend; sampled only on the accept edge.
- `b`  in  WIDTH: subtrahend; sampled only on the accept edge.
- `out_valid`  out  1: result valid and held stable.
- `out_ready`  in  1: consumer takes the result.
- `diff`  out  WIDTH: (a - b) mod 2^WIDTH.
- `borrow`  out  1: 1 when a < b, compared unsigned.
- `ovf`  out  1: signed overflow. Present only with `BIT_SERIAL_SUB_OVF_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: load shift registers `a_sh`=a and `b_sh`=b; clear the borrow register and the bit counter; go to RUN.
- **RUN**
  - `in_ready`=0.
  - Each cycle the cell computes `d = a_sh[0] ^ b_sh[0] ^ br` and `br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)`.
  - `d` shifts into the diff register at the MSB, which shifts right. `a_sh` and `b_sh` shift right. The counter increments.
  - When the counter reaches WIDTH-1 on the current bit, go to DONE after that edge.
- **DONE**
  - `out_valid`=1; `diff` and `borrow` (the final `br`) are held stable.
  - On `out_valid & out_ready`: go to IDLE and drop `out_valid`.
- Inputs `in_valid`, `a` and `b` are ignored outside IDLE. Changes to `a` or `b` after acceptance have no effect.
- The counter width is $clog2(WIDTH).
- Reset values: state=IDLE, `out_valid`=0, `diff`=0, `borrow`=0, `ovf`=0, counter=0.
- `in_ready` is decoded from state. It reads 1 while `rst_n` is low and after reset.

## Timing
- Accept on edge k. Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH. `out_valid` rises after edge k+WIDTH, a latency of WIDTH cycles.
- Result-handshake edge is j: `out_valid` falls and `in_ready` rises after edge j. The earliest next accept is edge j+1.
- There is no accept on the same edge as a result handshake. Back-to-back throughput is one operation per WIDTH+2 cycles when `out_ready` is held high.
- Backpressure: with `out_ready`=0, DONE holds indefinitely with all outputs stable.
- `rst_n` asserted at any time, including mid-RUN or during DONE, immediately aborts the operation. The partial result is discarded and outputs take their reset values asynchronously.

## Configuration
- Macro: `BIT_SERIAL_SUB_OVF_EN`.
- **Defined:**
  - The block captures `a[WIDTH-1]` and `b[WIDTH-1]` on accept.
  - In DONE, `ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb)`.
  - `ovf` is registered, reset to 0, and held with `diff`.
- **Undefined:** the `ovf` port and the sign capture registers do not exist. All other behaviour is identical.

## Structure
- Package `bit_serial_sub_pkg` holds:
  - the state enum `sub_state_t` {IDLE, RUN, DONE};
  - the default width constant `SUB_WIDTH_DEFAULT`=8.
- Sub-module `full_subtractor`: combinational cell with inputs x, y, bin and outputs d, bout, built from two half-subtractor stages plus an OR. It is instantiated once.

## Test plan
- a=8'd5, b=8'd3 -> diff=8'h02, borrow=0, ovf=0; `out_valid` rises exactly 8 cycles after the accept edge.
- a=8'd3, b=8'd5 -> diff=8'hFE, borrow=1, ovf=0. Also a=8'h00, b=8'hFF -> diff=8'h01, borrow=1.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1 with the macro defined; the `ovf` port is absent with it undefined.
- Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands -> diff, borrow and ovf stay stable, `in_ready`=0, and the new operands are not accepted. Accept happens on the edge after the result handshake.
- Assert `rst_n`=0 after bit 3 of a=8'hF0, b=8'h0F -> `out_valid`=0 and diff=0 immediately, `in_ready`=1. A following op with a=8'hFF, b=8'hFF -> diff=8'h00, borrow=0.
- Run 256 random operand pairs back-to-back with `out_ready`=1 -> every result matches (a-b) mod 256 and the unsigned borrow; the accept-to-accept spacing is 10 cycles.
